// File: rtl/mem_arbiter_if.sv
// ----------------------------------------------------------------------------
// mem_arbiter_if
//   Bundles every handshake/bus signal around mem_arbiter: the fetch port
//   (i_*), the load/store port (d_*), the shared downstream port (mem_*)
//   and the current owner (grant).
//
//   modport slave  : the arbiter's view (takes requests from fetch/LSU and
//                    responses from memory, drives acks, strobes and grant).
//   modport master : the surrounding system's view (core ports plus memory).
//
//   Parameters: ADDR_W address width, DATA_W data width (DATA_W/8 byte sels).
// ----------------------------------------------------------------------------
interface mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   localparam int SEL_W = DATA_W / 8;

   // fetch port (read-only)
   logic [ADDR_W-1:0] i_addr;
   logic              i_re;
   logic [DATA_W-1:0] i_rdata;
   logic              i_ack;
   // load/store port
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic [SEL_W-1:0]  d_sel;
   logic              d_re;
   logic              d_we;
   logic [DATA_W-1:0] d_rdata;
   logic              d_ack;
   // shared downstream port
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [SEL_W-1:0]  mem_sel;
   logic              mem_re;
   logic              mem_we;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;
   // owner: 00 none, 01 fetch, 10 data
   logic [1:0]        grant;

   modport slave (
      input  i_addr, i_re, d_addr, d_wdata, d_sel, d_re, d_we, mem_rdata, mem_ack,
      output i_rdata, i_ack, d_rdata, d_ack,
      output mem_addr, mem_wdata, mem_sel, mem_re, mem_we, grant
   );

   modport master (
      output i_addr, i_re, d_addr, d_wdata, d_sel, d_re, d_we, mem_rdata, mem_ack,
      input  i_rdata, i_ack, d_rdata, d_ack,
      input  mem_addr, mem_wdata, mem_sel, mem_re, mem_we, grant
   );
endinterface

// File: rtl/mem_arbiter.sv
// ----------------------------------------------------------------------------
// mem_arbiter
//   Shares one memory port between the instruction fetch port (read-only)
//   and the load/store data port. A registered grant FSM (IDLE/GNT_I/GNT_D)
//   picks the owner; all request/response muxing is combinational from the
//   registered state, so the downstream strobe appears one cycle after a
//   request from IDLE and an ack can complete in the first granted cycle.
//
//   Ports:
//     clk      system clock
//     reset_n  asynchronous active-low reset
//     bus      mem_arbiter_if.slave: fetch, data and downstream ports + grant
//
//   Arbitration:
//     - From IDLE, data wins a tie.
//     - On mem_ack the next owner is chosen at the same edge (no bubble)
//       among the other master's request and the current master's request
//       if still held. A master that has no further work drops its request
//       in the ack cycle; holding it across the ack edge asks for another
//       transfer.
//     - Without mem_ack the grant is held (no preemption), even if the
//       owner drops its request; the strobes simply follow the request.
//
//   Build option MEM_ARBITER_RR_EN:
//     defined   - round-robin: on a completion with both pending, the master
//                 that did not just complete wins; a last-owner register
//                 (reset to fetch) also breaks ties from IDLE.
//     undefined - fixed priority: data always wins ties; fetch can starve.
// ----------------------------------------------------------------------------
module mem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic         clk,
   input  logic         reset_n,
   mem_arbiter_if.slave bus
);
   localparam int SEL_W = DATA_W / 8;

   // encoding doubles as the grant output
   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      GNT_I = 2'b01,
      GNT_D = 2'b10
   } state_t;

   state_t state;

   logic i_pend, d_pend;
   logic idle_tie_d;   // tie from IDLE goes to data
   logic ack_tie_d;    // tie at a data completion goes back to data

   assign i_pend = bus.i_re;
   assign d_pend = bus.d_re | bus.d_we;

`ifdef MEM_ARBITER_RR_EN
   logic last_d;       // 1: data owned the most recent completion
   assign idle_tie_d = ~last_d;
   assign ack_tie_d  = 1'b0;
`else
   assign idle_tie_d = 1'b1;
   assign ack_tie_d  = 1'b1;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
`ifdef MEM_ARBITER_RR_EN
         last_d <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (d_pend && i_pend) state <= idle_tie_d ? GNT_D : GNT_I;
               else if (d_pend)      state <= GNT_D;
               else if (i_pend)      state <= GNT_I;
            end
            GNT_I: begin
               // fetch just completed, so data wins a tie in either mode
               if (bus.mem_ack) begin
                  if (d_pend)      state <= GNT_D;
                  else if (i_pend) state <= GNT_I;
                  else             state <= IDLE;
`ifdef MEM_ARBITER_RR_EN
                  last_d <= 1'b0;
`endif
               end
            end
            GNT_D: begin
               if (bus.mem_ack) begin
                  if (d_pend && i_pend) state <= ack_tie_d ? GNT_D : GNT_I;
                  else if (d_pend)      state <= GNT_D;
                  else if (i_pend)      state <= GNT_I;
                  else                  state <= IDLE;
`ifdef MEM_ARBITER_RR_EN
                  last_d <= 1'b1;
`endif
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // request/response routing from the registered owner
   logic [ADDR_W-1:0] addr_mux;
   logic [DATA_W-1:0] wdata_mux, i_rdata_mux, d_rdata_mux;
   logic [SEL_W-1:0]  sel_mux;
   logic              re_mux, we_mux, i_ack_mux, d_ack_mux;

   always_comb begin
      addr_mux    = '0;
      wdata_mux   = '0;
      sel_mux     = '0;
      re_mux      = 1'b0;
      we_mux      = 1'b0;
      i_ack_mux   = 1'b0;
      d_ack_mux   = 1'b0;
      i_rdata_mux = '0;
      d_rdata_mux = '0;
      case (state)
         GNT_I: begin
            addr_mux    = bus.i_addr;
            sel_mux     = '1;
            re_mux      = bus.i_re;
            i_ack_mux   = bus.mem_ack;
            i_rdata_mux = bus.mem_rdata;
         end
         GNT_D: begin
            addr_mux    = bus.d_addr;
            wdata_mux   = bus.d_wdata;
            sel_mux     = bus.d_sel;
            re_mux      = bus.d_re;
            we_mux      = bus.d_we;
            d_ack_mux   = bus.mem_ack;
            d_rdata_mux = bus.mem_rdata;
         end
         default: ;
      endcase
   end

   assign bus.mem_addr  = addr_mux;
   assign bus.mem_wdata = wdata_mux;
   assign bus.mem_sel   = sel_mux;
   assign bus.mem_re    = re_mux;
   assign bus.mem_we    = we_mux;
   assign bus.i_ack     = i_ack_mux;
   assign bus.i_rdata   = i_rdata_mux;
   assign bus.d_ack     = d_ack_mux;
   assign bus.d_rdata   = d_rdata_mux;
   assign bus.grant     = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed scenarios with constant expectations, then a randomized run in
//   which two master processes and a memory device exchange transfers; the
//   masters check returned data against their own word-array model of memory.
//   Build with +define+MEM_ARBITER_RR_EN to check the round-robin variant.
// ----------------------------------------------------------------------------
module tb_mem_arbiter;
   localparam int AW = 32;
   localparam int DW = 32;
`ifdef MEM_ARBITER_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        zw = 1'b0;          // zero-wait memory: ack follows strobe
   logic        mem_ack_r = 1'b0;
   logic [31:0] mem_rdata_r = '0;
   int          n_chk = 0;
   int          n_fail = 0;

   mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   assign bus.mem_ack   = zw ? (bus.mem_re | bus.mem_we) : mem_ack_r;
   assign bus.mem_rdata = mem_rdata_r;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic edge1();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_in();
      bus.i_addr = '0; bus.i_re = 1'b0;
      bus.d_addr = '0; bus.d_wdata = '0; bus.d_sel = '0;
      bus.d_re = 1'b0; bus.d_we = 1'b0;
      zw = 1'b0; mem_ack_r = 1'b0; mem_rdata_r = '0;
   endtask

   task automatic do_reset();
      clr_in();
      reset_n = 1'b0;
      edge1();
      edge1();
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      clr_in();
      reset_n = 1'b0;
      edge1();
      edge1();
      n_chk++;
      if ({bus.grant, bus.mem_re, bus.mem_we, bus.i_ack, bus.d_ack, bus.mem_addr, bus.mem_wdata, bus.mem_sel} !== '0) begin
         n_fail++;
         $display("FAIL reset_state: got grant=%b re=%b we=%b addr=%h wdata=%h sel=%b, expected all zero",
                  bus.grant, bus.mem_re, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_sel);
      end
      reset_n = 1'b1;
      bus.d_re = 1'b1; bus.d_addr = 32'h40;
      edge1();
      n_chk++;
      if ({bus.grant, bus.mem_re} !== 3'b101) begin
         n_fail++; $display("FAIL reset_pre_gnt_d: got grant=%b mem_re=%b, expected 10/1", bus.grant, bus.mem_re);
      end
      #1 reset_n = 1'b0;
      #1;
      n_chk++;
      if ({bus.mem_re, bus.d_ack, bus.grant} !== 4'b0000) begin
         n_fail++; $display("FAIL reset_async: got mem_re=%b d_ack=%b grant=%b, expected 0/0/00", bus.mem_re, bus.d_ack, bus.grant);
      end
      edge1();
      reset_n = 1'b1;
      edge1();
      n_chk++;
      if ({bus.grant, bus.mem_addr} !== {2'b10, 32'h40}) begin
         n_fail++; $display("FAIL reset_rearb: got grant=%b addr=%h, expected 10/00000040", bus.grant, bus.mem_addr);
      end
      mem_ack_r = 1'b1; mem_rdata_r = 32'h55;
      #1;
      n_chk++;
      if ({bus.d_ack, bus.d_rdata, bus.i_ack} !== {1'b1, 32'h55, 1'b0}) begin
         n_fail++; $display("FAIL reset_rearb_ack: got d_ack=%b d_rdata=%h i_ack=%b, expected 1/00000055/0", bus.d_ack, bus.d_rdata, bus.i_ack);
      end
      bus.d_re = 1'b0;
      edge1();
      mem_ack_r = 1'b0;
      n_chk++;
      if (bus.grant !== 2'b00) begin
         n_fail++; $display("FAIL reset_idle_after: got grant=%b, expected 00", bus.grant);
      end
   endtask

   task automatic test_single_fetch();
      do_reset();
      bus.i_re = 1'b1; bus.i_addr = 32'h100;
      edge1();
      n_chk++;
      if ({bus.grant, bus.mem_addr, bus.mem_sel, bus.mem_re, bus.i_ack} !== {2'b01, 32'h100, 4'hf, 1'b1, 1'b0}) begin
         n_fail++; $display("FAIL fetch_grant: got grant=%b addr=%h sel=%b re=%b i_ack=%b, expected 01/00000100/1111/1/0",
                            bus.grant, bus.mem_addr, bus.mem_sel, bus.mem_re, bus.i_ack);
      end
      edge1();
      n_chk++;
      if ({bus.grant, bus.i_ack} !== 3'b010) begin
         n_fail++; $display("FAIL fetch_wait: got grant=%b i_ack=%b, expected 01/0", bus.grant, bus.i_ack);
      end
      edge1();
      mem_ack_r = 1'b1; mem_rdata_r = 32'hDEADBEEF;
      #1;
      n_chk++;
      if ({bus.i_ack, bus.i_rdata, bus.d_ack, bus.d_rdata} !== {1'b1, 32'hDEADBEEF, 1'b0, 32'h0}) begin
         n_fail++; $display("FAIL fetch_ack: got i_ack=%b i_rdata=%h d_ack=%b d_rdata=%h, expected 1/deadbeef/0/0",
                            bus.i_ack, bus.i_rdata, bus.d_ack, bus.d_rdata);
      end
      bus.i_re = 1'b0;
      edge1();
      mem_ack_r = 1'b0; mem_rdata_r = '0;
      #1;
      n_chk++;
      if ({bus.i_ack, bus.grant} !== 3'b000) begin
         n_fail++; $display("FAIL fetch_done: got i_ack=%b grant=%b, expected 0/00", bus.i_ack, bus.grant);
      end
   endtask

   task automatic test_simultaneous();
      do_reset();
      bus.i_re = 1'b1; bus.i_addr = 32'h300;
      bus.d_we = 1'b1; bus.d_addr = 32'h2000; bus.d_wdata = 32'h12345678; bus.d_sel = 4'b0011;
      mem_rdata_r = 32'hA5A5A5A5;
      edge1();
      n_chk++;
      if ({bus.grant, bus.mem_we, bus.mem_re, bus.mem_sel, bus.mem_addr, bus.mem_wdata} !== {2'b10, 1'b1, 1'b0, 4'b0011, 32'h2000, 32'h12345678}) begin
         n_fail++; $display("FAIL sim_data_first: got grant=%b we=%b re=%b sel=%b addr=%h wdata=%h, expected 10/1/0/0011/00002000/12345678",
                            bus.grant, bus.mem_we, bus.mem_re, bus.mem_sel, bus.mem_addr, bus.mem_wdata);
      end
      mem_ack_r = 1'b1;
      #1;
      n_chk++;
      if ({bus.d_ack, bus.i_ack, bus.i_rdata} !== {1'b1, 1'b0, 32'h0}) begin
         n_fail++; $display("FAIL sim_data_ack: got d_ack=%b i_ack=%b i_rdata=%h, expected 1/0/0", bus.d_ack, bus.i_ack, bus.i_rdata);
      end
      bus.d_we = 1'b0;
      edge1();
      mem_rdata_r = 32'h0BADF00D;
      #1;
      n_chk++;
      if ({bus.grant, bus.mem_re, bus.mem_we, bus.mem_addr, bus.mem_sel, bus.mem_wdata, bus.i_ack, bus.i_rdata, bus.d_ack, bus.d_rdata}
          !== {2'b01, 1'b1, 1'b0, 32'h300, 4'hf, 32'h0, 1'b1, 32'h0BADF00D, 1'b0, 32'h0}) begin
         n_fail++; $display("FAIL sim_fetch_next: got grant=%b re=%b we=%b addr=%h sel=%b wdata=%h i_ack=%b i_rdata=%h d_ack=%b d_rdata=%h, expected 01/1/0/300/1111/0/1/0badf00d/0/0",
                            bus.grant, bus.mem_re, bus.mem_we, bus.mem_addr, bus.mem_sel, bus.mem_wdata, bus.i_ack, bus.i_rdata, bus.d_ack, bus.d_rdata);
      end
      bus.i_re = 1'b0;
      edge1();
      mem_ack_r = 1'b0;
      n_chk++;
      if (bus.grant !== 2'b00) begin
         n_fail++; $display("FAIL sim_idle: got grant=%b, expected 00", bus.grant);
      end
   endtask

   task automatic test_zero_wait();
      logic [31:0] a;
      do_reset();
      zw = 1'b1;
      bus.i_re = 1'b1; bus.i_addr = 32'h400;
      #1;
      n_chk++;
      if (bus.i_ack !== 1'b0) begin
         n_fail++; $display("FAIL zw_first: got i_ack=%b, expected 0", bus.i_ack);
      end
      for (int k = 0; k < 6; k++) begin
         edge1();
         a = 32'h400 + 32'(4 * k);
         bus.i_addr = a;
         mem_rdata_r = ~a;
         #1;
         n_chk++;
         if ({bus.grant, bus.i_ack, bus.mem_addr, bus.i_rdata} !== {2'b01, 1'b1, a, ~a}) begin
            n_fail++; $display("FAIL zw_fetch%0d: got grant=%b i_ack=%b addr=%h rdata=%h, expected 01/1/%h/%h",
                               k, bus.grant, bus.i_ack, bus.mem_addr, bus.i_rdata, a, ~a);
         end
      end
      zw = 1'b0; mem_ack_r = 1'b1;
      bus.i_re = 1'b0;
      edge1();
      mem_ack_r = 1'b0;
      n_chk++;
      if (bus.grant !== 2'b00) begin
         n_fail++; $display("FAIL zw_idle: got grant=%b, expected 00", bus.grant);
      end
   endtask

   task automatic test_priority();
      logic [1:0] exp_g;
      int i_cnt;
      do_reset();
      i_cnt = 0;
      zw = 1'b1;
      bus.d_re = 1'b1; bus.d_addr = 32'h800;
      bus.i_re = 1'b1; bus.i_addr = 32'h900;
      mem_rdata_r = 32'h77;
      for (int k = 0; k < 8; k++) begin
         edge1();
         exp_g = (RR && (k % 2 == 1)) ? 2'b01 : 2'b10;
         n_chk++;
         if ({bus.grant, bus.i_ack, bus.d_ack} !== {exp_g, exp_g == 2'b01, exp_g == 2'b10}) begin
            n_fail++; $display("FAIL prio_cycle%0d: got grant=%b i_ack=%b d_ack=%b, expected grant=%b",
                               k, bus.grant, bus.i_ack, bus.d_ack, exp_g);
         end
         if (bus.i_ack) i_cnt++;
      end
      n_chk++;
      if (i_cnt !== (RR ? 4 : 0)) begin
         n_fail++; $display("FAIL prio_fetch_count: got %0d, expected %0d", i_cnt, RR ? 4 : 0);
      end
      zw = 1'b0; mem_ack_r = 1'b1;
      bus.i_re = 1'b0; bus.d_re = 1'b0;
      edge1();
      mem_ack_r = 1'b0;
      n_chk++;
      if (bus.grant !== 2'b00) begin
         n_fail++; $display("FAIL prio_idle: got grant=%b, expected 00", bus.grant);
      end
   endtask

   task automatic test_no_preempt();
      do_reset();
      bus.i_re = 1'b1; bus.i_addr = 32'hA00;
      edge1();
      n_chk++;
      if (bus.grant !== 2'b01) begin
         n_fail++; $display("FAIL np_grant: got grant=%b, expected 01", bus.grant);
      end
      bus.d_re = 1'b1; bus.d_addr = 32'hB00;
      for (int k = 0; k < 5; k++) begin
         edge1();
         n_chk++;
         if ({bus.grant, bus.mem_addr, bus.i_ack} !== {2'b01, 32'hA00, 1'b0}) begin
            n_fail++; $display("FAIL np_hold%0d: got grant=%b addr=%h i_ack=%b, expected 01/00000a00/0",
                               k, bus.grant, bus.mem_addr, bus.i_ack);
         end
      end
      mem_ack_r = 1'b1; mem_rdata_r = 32'hCAFE;
      #1;
      n_chk++;
      if ({bus.i_ack, bus.i_rdata, bus.d_ack} !== {1'b1, 32'hCAFE, 1'b0}) begin
         n_fail++; $display("FAIL np_ack: got i_ack=%b i_rdata=%h d_ack=%b, expected 1/0000cafe/0", bus.i_ack, bus.i_rdata, bus.d_ack);
      end
      bus.i_re = 1'b0;
      edge1();
      mem_ack_r = 1'b0;
      #1;
      n_chk++;
      if ({bus.grant, bus.mem_addr, bus.mem_re} !== {2'b10, 32'hB00, 1'b1}) begin
         n_fail++; $display("FAIL np_switch: got grant=%b addr=%h re=%b, expected 10/00000b00/1", bus.grant, bus.mem_addr, bus.mem_re);
      end
      mem_ack_r = 1'b1;
      #1 bus.d_re = 1'b0;
      edge1();
      mem_ack_r = 1'b0;
      n_chk++;
      if (bus.grant !== 2'b00) begin
         n_fail++; $display("FAIL np_idle: got grant=%b, expected 00", bus.grant);
      end
   endtask

   // Two random masters and a random-latency memory device. Each master
   // keeps its own copy of memory and checks read data on its ack.
   task automatic test_random();
      logic [31:0] model [16];
      logic [31:0] dev [16];
      logic [31:0] i_a, d_a, d_wd, v;
      logic [3:0]  d_s, idx;
      bit          i_act, d_act, d_wr, i_chain, d_chain, gen, fetch_ok, data_ok;
      int          i_age, d_age, issued, done;
      do_reset();
      for (int i = 0; i < 16; i++) begin
         v = $urandom;
         model[i] = v;
         dev[i] = v;
      end
      i_act = 0; d_act = 0; i_chain = 0; d_chain = 0; d_wr = 0;
      i_a = '0; d_a = '0; d_wd = '0; d_s = '0;
      i_age = 0; d_age = 0; issued = 0; done = 0;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         edge1();
         gen = (cyc < 3000);
         if (!gen && !i_act && !d_act && !i_chain && !d_chain) break;
         if (i_chain || (!i_act && gen && $urandom_range(0, 2) == 0)) begin
            i_act = 1; i_chain = 0; i_age = 0; issued++;
            i_a = 32'($urandom_range(0, 15)) << 2;
            bus.i_re = 1'b1; bus.i_addr = i_a;
         end
         if (d_chain || (!d_act && gen && $urandom_range(0, 2) == 0)) begin
            d_act = 1; d_chain = 0; d_age = 0; issued++;
            d_wr = 1'($urandom_range(0, 1));
            d_a = 32'($urandom_range(0, 15)) << 2;
            d_wd = $urandom;
            d_s = 4'($urandom_range(0, 15));
            bus.d_we = d_wr; bus.d_re = !d_wr;
            bus.d_addr = d_a; bus.d_wdata = d_wd; bus.d_sel = d_s;
         end
         #1;
         // device side: strobes must carry exactly one master's request
         if (bus.mem_we) begin
            n_chk++;
            if (!(d_act && d_wr && !bus.mem_re && bus.mem_addr == d_a && bus.mem_wdata == d_wd && bus.mem_sel == d_s)) begin
               n_fail++; $display("FAIL rand_we_route: got addr=%h wdata=%h sel=%b, expected data write %h/%h/%b (active=%0d)",
                                  bus.mem_addr, bus.mem_wdata, bus.mem_sel, d_a, d_wd, d_s, d_act);
            end
         end
         if (bus.mem_re) begin
            fetch_ok = i_act && bus.mem_addr == i_a && bus.mem_sel == 4'hf && bus.mem_wdata == 32'h0 && !bus.mem_we;
            data_ok  = d_act && !d_wr && bus.mem_addr == d_a && bus.mem_sel == d_s && bus.mem_wdata == d_wd;
            n_chk++;
            if (!(fetch_ok || data_ok)) begin
               n_fail++; $display("FAIL rand_re_route: got addr=%h sel=%b wdata=%h, expected fetch %h or data read %h/%b",
                                  bus.mem_addr, bus.mem_sel, bus.mem_wdata, i_a, d_a, d_s);
            end
         end
         if ((bus.mem_re || bus.mem_we) && $urandom_range(0, 1) == 1) begin
            mem_ack_r = 1'b1;
            idx = bus.mem_addr[5:2];
            if (bus.mem_we) begin
               for (int b = 0; b < 4; b++)
                  if (bus.mem_sel[b]) dev[idx][8*b +: 8] = bus.mem_wdata[8*b +: 8];
               mem_rdata_r = $urandom;
            end else begin
               mem_rdata_r = dev[idx];
            end
         end else begin
            mem_ack_r = 1'b0;
            mem_rdata_r = $urandom;
         end
         #1;
         // master side
         n_chk++;
         if (bus.i_ack && bus.d_ack) begin
            n_fail++; $display("FAIL rand_both_ack: got i_ack=1 d_ack=1, expected at most one");
         end
         if (bus.i_ack) begin
            n_chk++;
            if (!i_act) begin
               n_fail++; $display("FAIL rand_i_spurious: got i_ack=1, expected 0 (no fetch outstanding)");
            end else begin
               if (bus.i_rdata !== model[i_a[5:2]]) begin
                  n_fail++; $display("FAIL rand_i_rdata: got %h, expected %h (addr %h)", bus.i_rdata, model[i_a[5:2]], i_a);
               end
               i_act = 0; done++;
               if (gen && $urandom_range(0, 1) == 1) i_chain = 1;
               else bus.i_re = 1'b0;
            end
         end
         if (bus.d_ack) begin
            n_chk++;
            if (!d_act) begin
               n_fail++; $display("FAIL rand_d_spurious: got d_ack=1, expected 0 (no data access outstanding)");
            end else begin
               if (d_wr) begin
                  for (int b = 0; b < 4; b++)
                     if (d_s[b]) model[d_a[5:2]][8*b +: 8] = d_wd[8*b +: 8];
               end else if (bus.d_rdata !== model[d_a[5:2]]) begin
                  n_fail++; $display("FAIL rand_d_rdata: got %h, expected %h (addr %h)", bus.d_rdata, model[d_a[5:2]], d_a);
               end
               d_act = 0; done++;
               if (gen && $urandom_range(0, 1) == 1) d_chain = 1;
               else begin bus.d_re = 1'b0; bus.d_we = 1'b0; end
            end
         end
         if (i_act) i_age++;
         if (d_act) d_age++;
         if (i_age > 200 || d_age > 200) begin
            n_chk++; n_fail++;
            $display("FAIL rand_timeout: got wait i=%0d d=%0d cycles, expected at most 200", i_age, d_age);
            break;
         end
      end
      n_chk++;
      if (done !== issued || done < 100) begin
         n_fail++; $display("FAIL rand_done: got %0d completions, expected %0d (at least 100)", done, issued);
      end
      clr_in();
      edge1();
   endtask

   initial begin
      test_reset();
      test_single_fetch();
      test_simultaneous();
      test_zero_wait();
      test_priority();
      test_no_preempt();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one memory port between two masters: the instruction fetch port (read-only) and the load/store data port (read/write).
- Sits between the core's fetch/LSU ports and the single external memory port.
- Registered grant FSM.
- Routes the granted master's request downstream; returns ack/rdata only to that master.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width; byte-select width is DATA_W/8

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
i_addr  input  ADDR_W  fetch request address
i_re  input  1  fetch read request, held until i_ack
i_rdata  output  DATA_W  fetch read data, valid when i_ack
i_ack  output  1  fetch transfer complete
d_addr  input  ADDR_W  data request address
d_wdata  input  DATA_W  data write data
d_sel  input  DATA_W/8  data byte selects
d_re  input  1  data read request, held until d_ack
d_we  input  1  data write request, held until d_ack; never with d_re
d_rdata  output  DATA_W  data read data, valid when d_ack
d_ack  output  1  data transfer complete
mem_addr  output  ADDR_W  downstream address
mem_wdata  output  DATA_W  downstream write data
mem_sel  output  DATA_W/8  downstream byte selects; fetch grant drives all ones
mem_re  output  1  downstream read strobe
mem_we  output  1  downstream write strobe
mem_rdata  input  DATA_W  downstream read data
mem_ack  input  1  downstream completion, one cycle per transfer, may arrive in the first granted cycle
grant  output  2  current owner: 00 none, 01 fetch, 10 data

Behaviour:
- Reset: asynchronous on reset_n low.
  - FSM to IDLE, grant=00.
  - mem_re=mem_we=0, i_ack=d_ack=0.
  - mem_addr/mem_wdata/mem_sel are 0 in IDLE.
- States: IDLE, GNT_I, GNT_D. State is registered; all request/response muxing is combinational from state.
- IDLE:
  - d_re|d_we pending -> GNT_D next edge.
  - Else i_re pending -> GNT_I next edge.
  - Else stay in IDLE.
  - Minimum latency from request to the downstream strobe is 1 cycle.
- GNT_I:
  - mem_addr=i_addr, mem_sel=all ones, mem_re=i_re, mem_we=0, mem_wdata=0.
  - i_ack=mem_ack, i_rdata=mem_rdata. d_ack=0.
- GNT_D:
  - mem_addr=d_addr, mem_wdata=d_wdata, mem_sel=d_sel, mem_re=d_re, mem_we=d_we.
  - d_ack=mem_ack, d_rdata=mem_rdata. i_ack=0.
- Rdata of the non-granted master reads 0.
- On mem_ack in a granted state, the next state is chosen at the same edge with no idle bubble:
  - Pending requests considered: the other master's request, plus the current master's request if it is still asserted after the ack.
  - Priority rule decides the winner (see Optional Feature).
  - No request pending -> IDLE.
- No mem_ack -> hold the grant. There is no preemption, even if a higher-priority request arrives.
- Granted master drops its request without ack (protocol violation): FSM holds the grant; downstream strobes follow the request, so they drop too.
- Both masters request in the same cycle from IDLE: data wins.
- Fetch holds i_re continuously: fetch takes the port whenever data is idle.

Optional Feature:
- Macro: MEM_ARBITER_RR_EN.
- Defined: round-robin at each completion.
  - If both masters are pending when mem_ack arrives, the grant goes to the master that did NOT just complete.
  - A last-owner register resets to fetch, so the first tie from IDLE still goes to data.
- Undefined: fixed priority. Data always wins ties, including back-to-back data requests, so fetch can starve.

Test Plan:
- Reset: assert reset_n=0 mid GNT_D with mem_re=1 -> mem_re=0, d_ack=0, grant=00 immediately without a clock edge; after release, pending requests are re-arbitrated from IDLE.
- Single fetch: i_re=1, i_addr=0x100; memory acks 2 cycles after mem_re, rdata=0xDEADBEEF -> grant=01 one cycle after request, mem_addr=0x100, mem_sel=4'b1111, i_ack pulses once with i_rdata=0xDEADBEEF, d_ack stays 0.
- Simultaneous request from IDLE: i_re=1 and d_we=1, d_addr=0x2000, d_wdata=0x12345678, d_sel=4'b0011 -> grant=10 first, mem_we=1, mem_sel=4'b0011; on ack, grant=01 at the same edge with no IDLE cycle.
- Zero-wait memory: mem_ack tied to mem_re|mem_we, fetch only -> i_ack asserted every cycle after the first, consecutive fetches back to back, grant stays 01.
- Priority: d_re and i_re held continuously, mem_ack every cycle -> without MEM_ARBITER_RR_EN grant stays 10 and i_ack is never asserted; with the macro, grant alternates 10,01,10,01.
- No preemption: in GNT_I with mem_ack withheld 5 cycles, d_re asserts -> grant stays 01 and mem_addr=i_addr until ack, then grant=10 the next cycle.
